lamp_seq_monitor: RTL and testbench
===================================

// Module: lamp_seq_monitor
// PURPOSE
//  Observer for the bound-flash lamp bus: samples lamps[MAX_LAMP-1:0] produced by the flasher,
//  decodes lit-lamp level, tracks sweep direction, counts reversals and completed sweeps,
//  and flags illegal patterns. Sits beside the flasher in the top level or in the bench as
//  a self-checking sink; it never drives the lamps.
// PARAMETERS
//  MAX_LAMP   16  width of lamp bus
//  LVL_W      $clog2(MAX_LAMP+1)  width of level/peak outputs (derived, localparam)
//  CNT_W      8   width of turn_cnt and sweep_cnt (saturating)
// PORTS
//  clk         in   1         system clock, rising edge
//  rst_n       in   1         asynchronous active-low reset
//  lamps       in   MAX_LAMP  lamp bus from flasher; bit0 = first lamp
//  sample_en   in   1         one-cycle strobe: lamps valid, evaluate this cycle
//  clr         in   1         synchronous clear of sticky error, turn_cnt, sweep_cnt, peak
//  level       out  LVL_W     lit-lamp count of last legal sample
//  dir         out  2         00 IDLE, 01 UP, 10 DOWN, 11 FAULT (= state)
//  peak        out  LVL_W     max level since reset/clr
//  turn_cnt    out  CNT_W     UP<->DOWN reversals, saturates at all-ones
//  sweep_cnt   out  CNT_W     returns to level 0 from DOWN, saturates
//  err_pattern out  1         1-cycle pulse: sample not thermometer code
//  err_step    out  1         1-cycle pulse: level changed by more than 1
//  err_sticky  out  1         set by any err pulse, cleared only by clr/reset
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, internal prev level 0.
//  - All outputs registered; result of a sample visible 1 cycle after sample_en high.
//  - No sample_en: all state and outputs hold; err pulses are 0.
//  - Legal pattern: lamps == (1<<k)-1, k in 0..MAX_LAMP; new level = k. delta = k - level.
//  - Non-thermometer sample: err_pattern=1, state->FAULT, level/peak unchanged.
//  - Thermometer, |delta|>1, state != FAULT: err_step=1, state->FAULT, level unchanged.
//  - State transitions on legal sample (|delta|<=1):
//     IDLE: +1 -> UP; 0 -> IDLE; (-1 impossible at level 0).
//     UP:   +1 -> UP; 0 -> UP; -1 -> DOWN, turn_cnt++.
//     DOWN: -1 -> DOWN, or IDLE if new level 0 (sweep_cnt++, no turn); 0 -> DOWN;
//           +1 -> UP, turn_cnt++.
//     FAULT: any delta ignored; only an all-zero sample resyncs -> IDLE, level=0
//            (no error pulse, no counter change). Other samples: no new pulses (one pulse per fault entry).
//  - level updates on every legal non-FAULT sample; peak = max(peak, new level).
//  - Counters saturate at 2^CNT_W-1, never wrap.
//  - clr same cycle as sample_en: sample processed first, then clr zeroes turn_cnt,
//    sweep_cnt, peak; err_sticky ends 1 if that sample raised an error (error wins), else 0.
//    clr does not affect level, state or err pulses.
//  - Async reset mid-sweep: immediate return to reset values; next sample judged against level 0.
// STRUCTURE
//  - Package lamp_mon_pkg: state encodings ST_IDLE/ST_UP/ST_DOWN/ST_FAULT (2-bit),
//    function thermo_level(lamps) -> {valid, level}, LVL_W derivation.
//  - One sub-module lamp_thermo_decode (combinational): lamps -> is_thermo, level.
//  - Top: state register, level/peak regs, two saturating counters, error pulse/sticky logic.
// TESTING (MAX_LAMP=16, CNT_W=8)
//  1 Reset then samples 0x0001,0x0003,0x0007 -> level 1,2,3, dir UP, peak 3, no errors.
//  2 From level 3 sample 0x0003 then 0x0007 -> dir DOWN then UP, turn_cnt=2, level 3.
//  3 Sweep 0x0001..0xFFFF then down to 0x0000 -> peak 16, turn_cnt 1, sweep_cnt 1, dir IDLE.
//  4 At level 2 sample 0x0005 -> err_pattern 1 cycle, dir FAULT, err_sticky 1, level 2;
//    then 0x0007 -> no pulse, still FAULT; then 0x0000 -> IDLE, level 0.
//  5 At level 2 sample 0x000F -> err_step 1 cycle, FAULT; clr with same-cycle error
//    -> err_sticky stays 1; clr alone next cycle -> err_sticky 0, peak 0, counters 0.
//  6 Reverse 300 times -> turn_cnt holds 255; assert rst_n low mid-sweep -> all outputs 0 at once.

Source files
------------

// File: rtl/lamp_mon_pkg.sv
// Shared types and helpers for the lamp bus monitor: state encodings,
// level-width derivation and the thermometer-code decoding function.
package lamp_mon_pkg;

  // Monitor state; the encoding is also the externally visible direction code.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_UP    = 2'b01,
    ST_DOWN  = 2'b10,
    ST_FAULT = 2'b11
  } mon_state_e;

  // Widest lamp bus the decoding function handles; callers zero-extend into it.
  localparam int THERMO_MAX = 64;
  // Level width able to hold 0..THERMO_MAX.
  localparam int THERMO_LW  = 8;

  // Result of decoding one lamp sample.
  typedef struct packed {
    logic                 valid;  // sample is a thermometer code
    logic [THERMO_LW-1:0] level;  // number of lit lamps
  } thermo_t;

  // Width needed to hold a lamp count of 0..n.
  function automatic int lvl_width(input int n);
    return $clog2(n + 1);
  endfunction

  // A legal pattern is a contiguous run of ones starting at bit 0.
  // Any lit lamp above an unlit one breaks the code.
  function automatic thermo_t thermo_level(input logic [THERMO_MAX-1:0] lamps);
    thermo_t r;
    logic    gap;
    r.valid = 1'b1;
    r.level = '0;
    gap     = 1'b0;
    for (int i = 0; i < THERMO_MAX; i++) begin
      if (lamps[i]) begin
        if (gap) begin
          r.valid = 1'b0;
        end
        r.level = r.level + THERMO_LW'(1);
      end else begin
        gap = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lamp_thermo_decode.sv
// Combinational decode of the lamp bus into a legality flag and a lit-lamp count.
module lamp_thermo_decode
  import lamp_mon_pkg::*;
#(
  parameter int MAX_LAMP = 16,
  parameter int LVL_W    = lvl_width(MAX_LAMP)
) (
  input  logic [MAX_LAMP-1:0] lamps,
  output logic                is_thermo,
  output logic [LVL_W-1:0]    level
);

  logic [THERMO_MAX-1:0] lamps_ext;
  thermo_t               dec;
  // Upper bits of the generic decoder level are always zero for this bus width.
  logic [THERMO_LW-1:0]  dec_level_unused;

  // Zero-extend the lamp bus to the decoder's fixed width.
  generate
    for (genvar gi = 0; gi < THERMO_MAX; gi++) begin : g_ext
      if (gi < MAX_LAMP) begin : g_bit
        assign lamps_ext[gi] = lamps[gi];
      end else begin : g_pad
        assign lamps_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign dec              = thermo_level(lamps_ext);
  assign is_thermo        = dec.valid;
  assign level            = dec.level[LVL_W-1:0];
  assign dec_level_unused = dec.level;

endmodule

// File: rtl/lamp_seq_monitor.sv
// Passive observer for the bound-flash lamp bus. Tracks the lit-lamp level,
// sweep direction, reversals and completed sweeps, and flags illegal samples.
// MAX_LAMP must not exceed lamp_mon_pkg::THERMO_MAX.
module lamp_seq_monitor
  import lamp_mon_pkg::*;
#(
  parameter  int MAX_LAMP = 16,
  parameter  int CNT_W    = 8,
  localparam int LVL_W    = lvl_width(MAX_LAMP)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MAX_LAMP-1:0] lamps,
  input  logic                sample_en,
  input  logic                clr,
  output logic [LVL_W-1:0]    level,
  output logic [1:0]          dir,
  output logic [LVL_W-1:0]    peak,
  output logic [CNT_W-1:0]    turn_cnt,
  output logic [CNT_W-1:0]    sweep_cnt,
  output logic                err_pattern,
  output logic                err_step,
  output logic                err_sticky
);

  localparam logic [LVL_W:0]   LVL_ONE = (LVL_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mon_state_e       state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] peak_q, peak_d;
  logic [CNT_W-1:0] turn_q, turn_d;
  logic [CNT_W-1:0] sweep_q, sweep_d;
  logic             err_pat_q, err_pat_d;
  logic             err_step_q, err_step_d;
  logic             sticky_q, sticky_d;

  // Decoded view of the current lamp sample.
  logic             is_thermo;
  logic [LVL_W-1:0] new_level;

  lamp_thermo_decode #(
    .MAX_LAMP (MAX_LAMP),
    .LVL_W    (LVL_W)
  ) u_decode (
    .lamps     (lamps),
    .is_thermo (is_thermo),
    .level     (new_level)
  );

  // Step classification; one extra bit so level+1 cannot overflow.
  logic [LVL_W:0] cur_ext;
  logic [LVL_W:0] new_ext;
  logic           step_up;
  logic           step_dn;
  logic           step_same;
  logic           step_legal;
  logic           lamps_zero;

  assign cur_ext    = {1'b0, level_q};
  assign new_ext    = {1'b0, new_level};
  assign step_up    = (new_ext == cur_ext + LVL_ONE);
  assign step_dn    = (new_ext + LVL_ONE == cur_ext);
  assign step_same  = (new_ext == cur_ext);
  assign step_legal = step_up | step_dn | step_same;
  assign lamps_zero = (lamps == '0);

  // Saturating increments shared by the transition logic.
  logic [CNT_W-1:0] turn_inc;
  logic [CNT_W-1:0] sweep_inc;

  assign turn_inc  = (turn_q == CNT_MAX) ? turn_q : turn_q + CNT_ONE;
  assign sweep_inc = (sweep_q == CNT_MAX) ? sweep_q : sweep_q + CNT_ONE;

  // Next-state, level, counter and error evaluation for one sample.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    peak_d     = peak_q;
    turn_d     = turn_q;
    sweep_d    = sweep_q;
    err_pat_d  = 1'b0;
    err_step_d = 1'b0;
    sticky_d   = sticky_q;

    if (sample_en) begin
      if (state_q == ST_FAULT) begin
        // Only an all-dark bus resyncs; nothing else is judged while faulted.
        if (lamps_zero) begin
          state_d = ST_IDLE;
          level_d = '0;
        end
      end else if (!is_thermo) begin
        err_pat_d = 1'b1;
        state_d   = ST_FAULT;
      end else if (!step_legal) begin
        err_step_d = 1'b1;
        state_d    = ST_FAULT;
      end else begin
        level_d = new_level;
        if (new_level > peak_q) begin
          peak_d = new_level;
        end
        unique case (state_q)
          ST_IDLE: begin
            if (step_up) begin
              state_d = ST_UP;
            end
          end
          ST_UP: begin
            if (step_dn) begin
              state_d = ST_DOWN;
              turn_d  = turn_inc;
            end
          end
          ST_DOWN: begin
            if (step_dn) begin
              // Reaching the bottom while descending closes a sweep.
              if (new_level == '0) begin
                state_d = ST_IDLE;
                sweep_d = sweep_inc;
              end
            end else if (step_up) begin
              state_d = ST_UP;
              turn_d  = turn_inc;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end

    if (err_pat_d || err_step_d) begin
      sticky_d = 1'b1;
    end

    // Clear applies after the sample; an error raised this cycle survives it.
    if (clr) begin
      turn_d   = '0;
      sweep_d  = '0;
      peak_d   = '0;
      sticky_d = err_pat_d | err_step_d;
    end
  end

  // State, level, peak, counter and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      level_q    <= '0;
      peak_q     <= '0;
      turn_q     <= '0;
      sweep_q    <= '0;
      err_pat_q  <= 1'b0;
      err_step_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      peak_q     <= peak_d;
      turn_q     <= turn_d;
      sweep_q    <= sweep_d;
      err_pat_q  <= err_pat_d;
      err_step_q <= err_step_d;
      sticky_q   <= sticky_d;
    end
  end

  assign level       = level_q;
  assign dir         = state_q;
  assign peak        = peak_q;
  assign turn_cnt    = turn_q;
  assign sweep_cnt   = sweep_q;
  assign err_pattern = err_pat_q;
  assign err_step    = err_step_q;
  assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_lamp_seq_monitor.sv
// Directed bench for lamp_seq_monitor with hand-computed expectations.
module tb_lamp_seq_monitor;

  logic        clk;
  logic        rst_n;
  logic [15:0] lamps;
  logic        sample_en;
  logic        clr;
  logic [4:0]  level;
  logic [1:0]  dir;
  logic [4:0]  peak;
  logic [7:0]  turn_cnt;
  logic [7:0]  sweep_cnt;
  logic        err_pattern;
  logic        err_step;
  logic        err_sticky;

  int n_vec;
  int n_bad;

  lamp_seq_monitor #(
    .MAX_LAMP (16),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lamps       (lamps),
    .sample_en   (sample_en),
    .clr         (clr),
    .level       (level),
    .dir         (dir),
    .peak        (peak),
    .turn_cnt    (turn_cnt),
    .sweep_cnt   (sweep_cnt),
    .err_pattern (err_pattern),
    .err_step    (err_step),
    .err_sticky  (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Present one sample for one clock; outputs are checked at the following negedge.
  task automatic do_sample(input logic [15:0] v, input logic c);
    @(negedge clk);
    lamps     = v;
    sample_en = 1'b1;
    clr       = c;
    @(negedge clk);
    sample_en = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".level"}, 32'(level), 32'd0);
    chk({tag, ".dir"}, 32'(dir), 32'd0);
    chk({tag, ".peak"}, 32'(peak), 32'd0);
    chk({tag, ".turn"}, 32'(turn_cnt), 32'd0);
    chk({tag, ".sweep"}, 32'(sweep_cnt), 32'd0);
    chk({tag, ".errpat"}, 32'(err_pattern), 32'd0);
    chk({tag, ".errstep"}, 32'(err_step), 32'd0);
    chk({tag, ".sticky"}, 32'(err_sticky), 32'd0);
  endtask

  initial begin
    logic [15:0] up_vec [3];
    logic [4:0]  up_lvl [3];
    logic [15:0] v;
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    lamps     = '0;
    sample_en = 1'b0;
    clr       = 1'b0;
    up_vec    = '{16'h0001, 16'h0003, 16'h0007};
    up_lvl    = '{5'd1, 5'd2, 5'd3};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");

    // 1: climbing samples
    for (int i = 0; i < 3; i++) begin
      do_sample(up_vec[i], 1'b0);
      chk($sformatf("t1.level%0d", i), 32'(level), 32'(up_lvl[i]));
      chk($sformatf("t1.dir%0d", i), 32'(dir), 32'd1);
    end
    chk("t1.peak", 32'(peak), 32'd3);
    chk("t1.sticky", 32'(err_sticky), 32'd0);
    // idle cycles must hold everything
    repeat (3) @(negedge clk);
    chk("t1.hold_level", 32'(level), 32'd3);

    // 2: reversal down then up
    do_sample(16'h0003, 1'b0);
    chk("t2.dir_down", 32'(dir), 32'd2);
    chk("t2.level2", 32'(level), 32'd2);
    chk("t2.turn1", 32'(turn_cnt), 32'd1);
    do_sample(16'h0007, 1'b0);
    chk("t2.dir_up", 32'(dir), 32'd1);
    chk("t2.turn2", 32'(turn_cnt), 32'd2);
    chk("t2.level3", 32'(level), 32'd3);

    // 3: full sweep up to 16 lamps and back to dark
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      v = 16'((32'd1 << k) - 32'd1);
      do_sample(v, 1'b0);
    end
    chk("t3.top_level", 32'(level), 32'd16);
    for (int k = 15; k >= 0; k--) begin
      v = 16'((32'd1 << k) - 32'd1);
      do_sample(v, 1'b0);
    end
    chk("t3.peak", 32'(peak), 32'd16);
    chk("t3.turn", 32'(turn_cnt), 32'd1);
    chk("t3.sweep", 32'(sweep_cnt), 32'd1);
    chk("t3.dir", 32'(dir), 32'd0);
    chk("t3.level", 32'(level), 32'd0);

    // 4: pattern error, fault hold, resync
    do_reset();
    do_sample(16'h0001, 1'b0);
    do_sample(16'h0003, 1'b0);
    do_sample(16'h0005, 1'b0);
    chk("t4.errpat", 32'(err_pattern), 32'd1);
    chk("t4.errstep", 32'(err_step), 32'd0);
    chk("t4.dir", 32'(dir), 32'd3);
    chk("t4.sticky", 32'(err_sticky), 32'd1);
    chk("t4.level", 32'(level), 32'd2);
    @(negedge clk);
    chk("t4.pulse_end", 32'(err_pattern), 32'd0);
    do_sample(16'h0007, 1'b0);
    chk("t4.nopulse_pat", 32'(err_pattern), 32'd0);
    chk("t4.nopulse_step", 32'(err_step), 32'd0);
    chk("t4.still_fault", 32'(dir), 32'd3);
    chk("t4.level_held", 32'(level), 32'd2);
    do_sample(16'h0000, 1'b0);
    chk("t4.resync_dir", 32'(dir), 32'd0);
    chk("t4.resync_level", 32'(level), 32'd0);
    chk("t4.resync_sticky", 32'(err_sticky), 32'd1);
    chk("t4.resync_nopulse", 32'(err_pattern), 32'd0);

    // 5: step error with same-cycle clear, then clear alone
    do_reset();
    do_sample(16'h0001, 1'b0);
    do_sample(16'h0003, 1'b0);
    do_sample(16'h0007, 1'b0);
    do_sample(16'h0003, 1'b0);
    chk("t5.pre_turn", 32'(turn_cnt), 32'd1);
    chk("t5.pre_peak", 32'(peak), 32'd3);
    do_sample(16'h000F, 1'b1);
    chk("t5.errstep", 32'(err_step), 32'd1);
    chk("t5.dir", 32'(dir), 32'd3);
    chk("t5.sticky_kept", 32'(err_sticky), 32'd1);
    chk("t5.level", 32'(level), 32'd2);
    chk("t5.peak_clr", 32'(peak), 32'd0);
    chk("t5.turn_clr", 32'(turn_cnt), 32'd0);
    do_clr();
    chk("t5.sticky_clr", 32'(err_sticky), 32'd0);
    chk("t5.errstep_end", 32'(err_step), 32'd0);
    chk("t5.dir_kept", 32'(dir), 32'd3);

    // 6: 300 reversals saturate, then async reset mid-sweep
    do_reset();
    do_sample(16'h0001, 1'b0);
    do_sample(16'h0003, 1'b0);
    for (int i = 0; i < 300; i++) begin
      v = (i % 2 == 0) ? 16'h0001 : 16'h0003;
      do_sample(v, 1'b0);
      if (i == 253) begin
        chk("t6.turn254", 32'(turn_cnt), 32'd254);
      end
    end
    chk("t6.turn_sat", 32'(turn_cnt), 32'd255);
    chk("t6.sweep", 32'(sweep_cnt), 32'd0);
    chk("t6.dir", 32'(dir), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6.async");
    @(negedge clk);
    rst_n = 1'b1;
    do_sample(16'h0003, 1'b0);
    chk("t6.after_errstep", 32'(err_step), 32'd1);
    chk("t6.after_dir", 32'(dir), 32'd3);
    chk("t6.after_level", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
